sap1_controller: RTL and testbench

//  Control sequencer for the SAP-1 datapath. It issues the control word that every
//  bus register obeys, including nLb for register B.
//  A 6-state ring counter (T1..T6) steps through fetch (T1-T3) and execute (T4-T6).
//  In execute, OPCODE from the instruction register is decoded into load/enable strobes.

---
 rtl/sap1_controller.sv | 173 +++++++++++++++++
 tb/tb_sap1_controller.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/sap1_controller.sv
// ---------------------------------------------------------------------------
// sap1_controller
//   Control sequencer for the SAP-1 datapath. A six-state one-hot ring counter
//   (T1..T6) advances on the falling clock edge, so the control word it decodes
//   is settled before the rising edge on which the datapath registers load.
//   T1-T3 fetch the instruction. T4-T6 execute the opcode held in the IR.
//   HLT freezes the ring in T4 until nCLR is asserted.
//
// Ports
//   CLK     in   1  system clock (ring advances on negedge)
//   nCLR    in   1  asynchronous active-low clear
//   OPCODE  in   4  IR upper nibble, decoded during T4-T6
//   T       out  6  one-hot ring state, T[0]=T1 .. T[5]=T6
//   Cp      out  1  PC increment
//   Ep      out  1  PC drives bus
//   nLm     out  1  MAR load (active low)
//   nCE     out  1  RAM drives bus (active low)
//   nLi     out  1  IR load (active low)
//   nEi     out  1  IR operand drives bus (active low)
//   nLa     out  1  accumulator load (active low)
//   Ea      out  1  accumulator drives bus
//   Su      out  1  ALU subtract select
//   Eu      out  1  ALU drives bus
//   nLb     out  1  register B load (active low)
//   nLo     out  1  output register load (active low)
//   HLT     out  1  halt indication to the clock gate
// ---------------------------------------------------------------------------
module sap1_controller (
    input  logic       CLK,
    input  logic       nCLR,
    input  logic [3:0] OPCODE,
    output logic [5:0] T,
    output logic       Cp,
    output logic       Ep,
    output logic       nLm,
    output logic       nCE,
    output logic       nLi,
    output logic       nEi,
    output logic       nLa,
    output logic       Ea,
    output logic       Su,
    output logic       Eu,
    output logic       nLb,
    output logic       nLo,
    output logic       HLT
);

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    typedef enum logic [5:0] {
        S_T1 = 6'b000001,
        S_T2 = 6'b000010,
        S_T3 = 6'b000100,
        S_T4 = 6'b001000,
        S_T5 = 6'b010000,
        S_T6 = 6'b100000
    } ring_t;

    ring_t ring_q, ring_d;
    logic  halted_q, halted_d;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its inputs regardless of statement order.
    always_ff @(negedge CLK or negedge nCLR) begin
        if (!nCLR) begin
            ring_q   <= S_T1;
            halted_q <= 1'b0;
        end else begin
            ring_q   <= ring_d;
            halted_q <= halted_d;
        end
    end

    // Next-state: the ring holds in T4 once HLT is seen and stays frozen.
    always_comb begin
        ring_d   = ring_q;
        halted_d = halted_q;
        if (!halted_q) begin
            if (ring_q == S_T4 && OPCODE == OP_HLT) begin
                halted_d = 1'b1;
            end else begin
                case (ring_q)
                    S_T1:    ring_d = S_T2;
                    S_T2:    ring_d = S_T3;
                    S_T3:    ring_d = S_T4;
                    S_T4:    ring_d = S_T5;
                    S_T5:    ring_d = S_T6;
                    S_T6:    ring_d = S_T1;
                    default: ring_d = S_T1; // recover from any non-one-hot value
                endcase
            end
        end
    end

    assign T = ring_q;

    // Control word decode. Gating with nCLR keeps every strobe inactive while
    // clear is held, independent of the flop state.
    // NOTE: every output gets its inactive value first so no path through the
    // decode leaves a signal unassigned (which would infer a latch).
    always_comb begin
        Cp  = 1'b0;
        Ep  = 1'b0;
        nLm = 1'b1;
        nCE = 1'b1;
        nLi = 1'b1;
        nEi = 1'b1;
        nLa = 1'b1;
        Ea  = 1'b0;
        Su  = 1'b0;
        Eu  = 1'b0;
        nLb = 1'b1;
        nLo = 1'b1;
        HLT = 1'b0;
        if (nCLR) begin
            if (halted_q) begin
                HLT = 1'b1;
            end else begin
                case (ring_q)
                    S_T1: begin
                        Ep  = 1'b1;
                        nLm = 1'b0;
                    end
                    S_T2: Cp = 1'b1;
                    S_T3: begin
                        nCE = 1'b0;
                        nLi = 1'b0;
                    end
                    S_T4: begin
                        case (OPCODE)
                            OP_LDA, OP_ADD, OP_SUB: begin
                                nEi = 1'b0;
                                nLm = 1'b0;
                            end
                            OP_OUT: begin
                                Ea  = 1'b1;
                                nLo = 1'b0;
                            end
                            OP_HLT:  HLT = 1'b1;
                            default: ;
                        endcase
                    end
                    S_T5: begin
                        case (OPCODE)
                            OP_LDA: begin
                                nCE = 1'b0;
                                nLa = 1'b0;
                            end
                            OP_ADD, OP_SUB: begin
                                nCE = 1'b0;
                                nLb = 1'b0;
                            end
                            default: ;
                        endcase
                    end
                    S_T6: begin
                        if (OPCODE == OP_ADD || OPCODE == OP_SUB) begin
                            Eu  = 1'b1;
                            nLa = 1'b0;
                            Su  = (OPCODE == OP_SUB);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sap1_controller.sv
// ---------------------------------------------------------------------------
// tb_sap1_controller
//   Directed bench for sap1_controller. Expected control words are written out
//   by hand as 13-bit constants in the order
//   {Cp,Ep,nLm,nCE,nLi,nEi,nLa,Ea,Su,Eu,nLb,nLo,HLT}.
//   Outputs are sampled 1 time unit after the rising edge, mid-way between
//   the falling edges that advance the ring.
// ---------------------------------------------------------------------------
module tb_sap1_controller;

    logic       CLK = 1'b0;
    logic       nCLR = 1'b0;
    logic [3:0] OPCODE = 4'b0000;
    logic [5:0] T;
    logic Cp, Ep, nLm, nCE, nLi, nEi, nLa, Ea, Su, Eu, nLb, nLo, HLT;
    logic [12:0] cw;

    int checks = 0;
    int failures = 0;

    //                                 Cp Ep Lm CE Li Ei La Ea Su Eu Lb Lo H
    localparam logic [12:0] W_IDLE  = 13'b0__0__1__1__1__1__1__0__0__0__1__1__0;
    localparam logic [12:0] W_T1    = 13'b0__1__0__1__1__1__1__0__0__0__1__1__0;
    localparam logic [12:0] W_T2    = 13'b1__0__1__1__1__1__1__0__0__0__1__1__0;
    localparam logic [12:0] W_T3    = 13'b0__0__1__0__0__1__1__0__0__0__1__1__0;
    localparam logic [12:0] W_T4M   = 13'b0__0__0__1__1__0__1__0__0__0__1__1__0;
    localparam logic [12:0] W_T4O   = 13'b0__0__1__1__1__1__1__1__0__0__1__0__0;
    localparam logic [12:0] W_T5L   = 13'b0__0__1__0__1__1__0__0__0__0__1__1__0;
    localparam logic [12:0] W_T5B   = 13'b0__0__1__0__1__1__1__0__0__0__0__1__0;
    localparam logic [12:0] W_T6A   = 13'b0__0__1__1__1__1__0__0__0__1__1__1__0;
    localparam logic [12:0] W_T6S   = 13'b0__0__1__1__1__1__0__0__1__1__1__1__0;
    localparam logic [12:0] W_HALT  = 13'b0__0__1__1__1__1__1__0__0__0__1__1__1;

    sap1_controller dut (
        .CLK    (CLK),
        .nCLR   (nCLR),
        .OPCODE (OPCODE),
        .T      (T),
        .Cp     (Cp),
        .Ep     (Ep),
        .nLm    (nLm),
        .nCE    (nCE),
        .nLi    (nLi),
        .nEi    (nEi),
        .nLa    (nLa),
        .Ea     (Ea),
        .Su     (Su),
        .Eu     (Eu),
        .nLb    (nLb),
        .nLo    (nLo),
        .HLT    (HLT)
    );

    assign cw = {Cp, Ep, nLm, nCE, nLi, nEi, nLa, Ea, Su, Eu, nLb, nLo, HLT};

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One call crosses exactly one falling edge, then samples mid-state.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [12:0] exp_cw(input logic [3:0] op, input int t);
        case (t)
            0: return W_T1;
            1: return W_T2;
            2: return W_T3;
            3: case (op)
                   4'b0000, 4'b0001, 4'b0010: return W_T4M;
                   4'b1110: return W_T4O;
                   4'b1111: return W_HALT;
                   default: return W_IDLE;
               endcase
            4: case (op)
                   4'b0000:          return W_T5L;
                   4'b0001, 4'b0010: return W_T5B;
                   default:          return W_IDLE;
               endcase
            5: case (op)
                   4'b0001: return W_T6A;
                   4'b0010: return W_T6S;
                   default: return W_IDLE;
               endcase
            default: return W_IDLE;
        endcase
    endfunction

    task automatic check_state(input string tag, input logic [5:0] t_exp, input logic [12:0] cw_exp);
        int bus_cnt;
        bus_cnt = int'(Ep) + int'(!nCE) + int'(!nEi) + int'(Ea) + int'(Eu);
        check({tag, ".T"}, 32'(T), 32'(t_exp));
        check({tag, ".cw"}, 32'(cw), 32'(cw_exp));
        check({tag, ".onehot"}, 32'($onehot(T)), 32'd1);
        check({tag, ".bus"}, 32'(bus_cnt <= 1), 32'd1);
    endtask

    // Runs one full T1..T6 instruction starting from T1; ends back in T1.
    task automatic run_instr(input string tag, input logic [3:0] op);
        OPCODE = op;
        for (int t = 0; t < 6; t++) begin
            check_state($sformatf("%s.T%0d", tag, t + 1), 6'(1 << t), exp_cw(op, t));
            step();
        end
        check_state({tag, ".wrap"}, 6'b000001, W_T1);
    endtask

    initial begin
        logic [3:0] rop;

        // Reset held across several edges: ring parked in T1, strobes inactive.
        nCLR = 1'b0;
        repeat (3) step();
        check_state("reset", 6'b000001, W_IDLE);
        nCLR = 1'b1;
        #1;
        check_state("release", 6'b000001, W_T1);

        run_instr("add", 4'b0001);
        run_instr("sub", 4'b0010);
        run_instr("out", 4'b1110);
        run_instr("lda", 4'b0000);
        run_instr("unk5", 4'b0101);

        // Reset in the middle of ADD (T5, nLb active) kills the strobe at once.
        OPCODE = 4'b0001;
        repeat (4) step();
        check_state("mid.T5", 6'b010000, W_T5B);
        nCLR = 1'b0;
        #1;
        check_state("mid.rst", 6'b000001, W_IDLE);
        step();
        check_state("mid.hold", 6'b000001, W_IDLE);
        nCLR = 1'b1;
        #1;
        check_state("mid.rel", 6'b000001, W_T1);

        // HLT: T4 asserts HLT, then the ring freezes in T4.
        OPCODE = 4'b1111;
        repeat (3) step();
        check_state("hlt.T4", 6'b001000, W_HALT);
        for (int i = 0; i < 20; i++) begin
            step();
            check_state($sformatf("hlt.frz%0d", i), 6'b001000, W_HALT);
        end
        // Changing OPCODE while halted must not wake the sequencer.
        OPCODE = 4'b0001;
        step();
        check_state("hlt.opchg", 6'b001000, W_HALT);
        nCLR = 1'b0;
        #1;
        check_state("hlt.rst", 6'b000001, W_IDLE);
        step();
        nCLR = 1'b1;
        #1;
        check_state("hlt.rel", 6'b000001, W_T1);
        run_instr("post_hlt_add", 4'b0001);

        // Random opcode run (HLT excluded so the run keeps going).
        for (int n = 0; n < 12; n++) begin
            rop = 4'($urandom_range(0, 14));
            run_instr($sformatf("rnd%0d_op%0h", n, rop), rop);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
